// File: rtl/snitch_vfpr_rd_frontend.sv
// Read frontend of the vector FP register file: accepts tagged multi-lane reads,
// issues per-lane memory requests and returns in-order results.
// Optional performance counters are enabled with `define SNITCH_VFPR_PERF_EN.

module snitch_vfpr_fifo #(
    parameter int unsigned Width       = 8,
    parameter int unsigned Depth       = 2,
    parameter bit          FallThrough = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] data_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_reg [Depth];
    logic [PtrWidth-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CntWidth-1:0] count_reg, count_next;
    logic                is_empty;
    logic                bypass;
    logic                store;
    logic                consume;

    assign is_empty = (count_reg == '0);
    // In fall-through mode a push into an empty FIFO that is popped in the
    // same cycle never touches storage.
    assign bypass   = FallThrough && is_empty && push_i && pop_i;
    assign store    = push_i && !bypass;
    assign consume  = pop_i && !is_empty;

    assign full_o   = (count_reg == CntWidth'(Depth));
    assign empty_o  = is_empty && !(FallThrough && push_i);
    assign data_o   = (FallThrough && is_empty) ? data_i : mem_reg[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (store) begin
            wr_ptr_next = (wr_ptr_reg == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (consume) begin
            rd_ptr_next = (rd_ptr_reg == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        case ({store, consume})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_reg[wr_ptr_reg] <= data_i;
        end
    end
endmodule

module snitch_vfpr_rd_frontend #(
    parameter int unsigned NumRdPorts     = 3,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned TagWidth       = 8,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned ReqBufDepth    = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             rvalid_i,
    output logic                             rready_o,
    input  logic [NumRdPorts*AddrWidth-1:0]  raddr_i,
    input  logic [NumRdPorts-1:0]            ren_i,
    input  logic [TagWidth-1:0]              rtag_i,
    output logic                             rvalid_o,
    input  logic                             rready_i,
    output logic [NumRdPorts*DataWidth-1:0]  rdata_o,
    output logic [TagWidth-1:0]              rtag_o,
    output logic [NumRdPorts-1:0]            mem_q_valid_o,
    input  logic [NumRdPorts-1:0]            mem_q_ready_i,
    output logic [NumRdPorts*AddrWidth-1:0]  mem_q_addr_o,
    input  logic [NumRdPorts-1:0]            mem_p_valid_i,
    input  logic [NumRdPorts*DataWidth-1:0]  mem_p_data_i,
    output logic [31:0]                      perf_issue_o,
    output logic [31:0]                      perf_stall_o
);
    localparam int unsigned CredWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned OpWidth   = TagWidth + NumRdPorts;

    logic                  ready_en_reg;
    logic                  op_full, op_empty;
    logic [OpWidth-1:0]    op_head;
    logic [TagWidth-1:0]   head_tag;
    logic [NumRdPorts-1:0] head_mask;
    logic                  accept, retire;

    logic [NumRdPorts-1:0] lane_ok;
    logic [NumRdPorts-1:0] lane_rdy;
    logic [NumRdPorts-1:0] req_full, req_empty, req_pop;
    logic [NumRdPorts-1:0] rsp_full, rsp_empty, rsp_pop;

    // Holds rready_o low while in reset and for the first cycle afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    assign rready_o = ready_en_reg && !op_full && (&lane_ok);
    assign accept   = rvalid_i && rready_o;
    assign rvalid_o = !op_empty && (&lane_rdy);
    assign retire   = rvalid_o && rready_i;

    assign head_tag  = op_head[OpWidth-1:NumRdPorts];
    assign head_mask = op_head[NumRdPorts-1:0];
    assign rtag_o    = op_empty ? '0 : head_tag;

    snitch_vfpr_fifo #(
        .Width      (OpWidth),
        .Depth      (MaxOutstanding),
        .FallThrough(1'b0)
    ) i_op_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (accept),
        .data_i ({rtag_i, ren_i}),
        .pop_i  (retire),
        .full_o (op_full),
        .empty_o(op_empty),
        .data_o (op_head)
    );

    for (genvar gi = 0; gi < NumRdPorts; gi++) begin : g_lane
        logic [AddrWidth-1:0] req_addr;
        logic [DataWidth-1:0] rsp_head;
        logic [CredWidth-1:0] credit_reg, credit_next;
        logic                 lane_push;
        logic                 cred_dec;

        assign lane_push = accept && ren_i[gi];
        assign cred_dec  = rsp_pop[gi];

        assign lane_ok[gi] = !ren_i[gi] ||
                             (!req_full[gi] && (credit_reg < CredWidth'(MaxOutstanding)));

        snitch_vfpr_fifo #(
            .Width      (AddrWidth),
            .Depth      (ReqBufDepth),
            .FallThrough(1'b0)
        ) i_req_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .push_i (lane_push),
            .data_i (raddr_i[gi*AddrWidth +: AddrWidth]),
            .pop_i  (req_pop[gi]),
            .full_o (req_full[gi]),
            .empty_o(req_empty[gi]),
            .data_o (req_addr)
        );

        assign mem_q_valid_o[gi]                      = !req_empty[gi];
        assign mem_q_addr_o[gi*AddrWidth +: AddrWidth] = req_addr;
        assign req_pop[gi]                            = !req_empty[gi] && mem_q_ready_i[gi];

        // Sized to MaxOutstanding: the credit counter bounds the number of
        // responses a lane can ever have buffered.
        snitch_vfpr_fifo #(
            .Width      (DataWidth),
            .Depth      (MaxOutstanding),
            .FallThrough(1'b1)
        ) i_rsp_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .push_i (mem_p_valid_i[gi]),
            .data_i (mem_p_data_i[gi*DataWidth +: DataWidth]),
            .pop_i  (rsp_pop[gi]),
            .full_o (rsp_full[gi]),
            .empty_o(rsp_empty[gi]),
            .data_o (rsp_head)
        );

        assign lane_rdy[gi] = !head_mask[gi] || !rsp_empty[gi];
        assign rsp_pop[gi]  = retire && head_mask[gi];

        assign rdata_o[gi*DataWidth +: DataWidth] =
            (!op_empty && head_mask[gi] && !rsp_empty[gi]) ? rsp_head : '0;

        always_comb begin
            credit_next = credit_reg;
            if (lane_push && !cred_dec) begin
                credit_next = credit_reg + 1'b1;
            end else if (cred_dec && !lane_push) begin
                credit_next = credit_reg - 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                credit_reg <= '0;
            end else begin
                credit_reg <= credit_next;
            end
        end

        rsp_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(mem_p_valid_i[gi] && rsp_full[gi]));
    end

`ifdef SNITCH_VFPR_PERF_EN
    logic [31:0] perf_issue_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issue_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (accept && (perf_issue_reg != 32'hFFFF_FFFF)) begin
                perf_issue_reg <= perf_issue_reg + 32'd1;
            end
            if (rvalid_i && !rready_o && (perf_stall_reg != 32'hFFFF_FFFF)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_issue_o = perf_issue_reg;
    assign perf_stall_o = perf_stall_reg;
`else
    assign perf_issue_o = '0;
    assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_snitch_vfpr_rd_frontend.sv
// Directed testbench for snitch_vfpr_rd_frontend with a 1-cycle per-lane memory model
// whose data word is {16'hDA7A, 16'(lane), addr}.
module tb_snitch_vfpr_rd_frontend;
    localparam int NL = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TW = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              rvalid_i;
    logic              rready_o;
    logic [NL*AW-1:0]  raddr_i;
    logic [NL-1:0]     ren_i;
    logic [TW-1:0]     rtag_i;
    logic              rvalid_o;
    logic              rready_i;
    logic [NL*DW-1:0]  rdata_o;
    logic [TW-1:0]     rtag_o;
    logic [NL-1:0]     mem_q_valid_o;
    logic [NL-1:0]     mem_q_ready_i;
    logic [NL*AW-1:0]  mem_q_addr_o;
    logic [NL-1:0]     mem_p_valid_i;
    logic [NL*DW-1:0]  mem_p_data_i;
    logic [31:0]       perf_issue_o;
    logic [31:0]       perf_stall_o;

    int checks = 0;
    int bad    = 0;

    snitch_vfpr_rd_frontend dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .raddr_i      (raddr_i),
        .ren_i        (ren_i),
        .rtag_i       (rtag_i),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .rdata_o      (rdata_o),
        .rtag_o       (rtag_o),
        .mem_q_valid_o(mem_q_valid_o),
        .mem_q_ready_i(mem_q_ready_i),
        .mem_q_addr_o (mem_q_addr_o),
        .mem_p_valid_i(mem_p_valid_i),
        .mem_p_data_i (mem_p_data_i),
        .perf_issue_o (perf_issue_o),
        .perf_stall_o (perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    // 1-cycle memory: answers every accepted request on the following cycle.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_p_valid_i <= '0;
            mem_p_data_i  <= '0;
        end else begin
            for (int l = 0; l < NL; l++) begin
                mem_p_valid_i[l] <= mem_q_valid_o[l] & mem_q_ready_i[l];
                mem_p_data_i[l*DW +: DW] <= {16'hDA7A, 16'(l), mem_q_addr_o[l*AW +: AW]};
            end
        end
    end

    function automatic logic [DW-1:0] memval(input int lane, input logic [AW-1:0] addr);
        return {16'hDA7A, 16'(lane), addr};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; rvalid_i = 1'b0; raddr_i = '0; ren_i = '0; rtag_i = '0;
        rready_i = 1'b1; mem_q_ready_i = '1;
        #2;
        checks++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
        checks++; if (rready_o !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b exp=0", rready_o); end
        checks++; if (mem_q_valid_o !== 3'b000) begin bad++; $display("FAIL reset_mem_q_valid got=%b exp=000", mem_q_valid_o); end
        checks++; if (rdata_o !== '0 || rtag_o !== 8'h00) begin bad++; $display("FAIL reset_data_tag got=%h/%h exp=0/0", rdata_o, rtag_o); end
        checks++; if (perf_issue_o !== 32'd0 || perf_stall_o !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_issue_o, perf_stall_o); end
        step();
        rst_ni = 1'b1;
        step(); step();
        $display("reset: outputs checked");
    endtask

    task automatic test_full_lanes();
        rvalid_i = 1'b1; ren_i = 3'b111; rtag_i = 8'h11;
        raddr_i = {32'h20, 32'h18, 32'h10};
        #1;
        checks++; if (rready_o !== 1'b1) begin bad++; $display("FAIL full_accept got=%b exp=1", rready_o); end
        step();
        rvalid_i = 1'b0;
        #1;
        checks++; if (mem_q_valid_o !== 3'b111 || rvalid_o !== 1'b0) begin bad++; $display("FAIL full_t1 q=%b rv=%b exp=111/0", mem_q_valid_o, rvalid_o); end
        step();
        checks++; if (rvalid_o !== 1'b1 || rtag_o !== 8'h11) begin bad++; $display("FAIL full_t2 rv=%b tag=%h exp=1/11", rvalid_o, rtag_o); end
        checks++; if (rdata_o !== {64'hDA7A0002_00000020, 64'hDA7A0001_00000018, 64'hDA7A0000_00000010}) begin
            bad++; $display("FAIL full_data got=%h", rdata_o); end
        step();
        checks++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL full_retire rv=%b exp=0", rvalid_o); end
        $display("full_lanes: tag 11 returned");
    endtask

    task automatic test_zero_mask();
        rvalid_i = 1'b1; ren_i = 3'b000; rtag_i = 8'h5A; raddr_i = '1;
        #1;
        checks++; if (rready_o !== 1'b1) begin bad++; $display("FAIL zero_accept got=%b exp=1", rready_o); end
        step();
        rvalid_i = 1'b0;
        #1;
        checks++; if (rvalid_o !== 1'b1 || rtag_o !== 8'h5A) begin bad++; $display("FAIL zero_t1 rv=%b tag=%h exp=1/5a", rvalid_o, rtag_o); end
        checks++; if (rdata_o !== '0 || mem_q_valid_o !== 3'b000) begin bad++; $display("FAIL zero_data d=%h q=%b exp=0/000", rdata_o, mem_q_valid_o); end
        step();
        $display("zero_mask: tag 5a returned");
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                rvalid_i = 1'b1; ren_i = 3'b111; rtag_i = 8'(8'h80 + c);
                for (int l = 0; l < NL; l++) raddr_i[l*AW +: AW] = 32'(32'h200 + 32'h40*c + 8*l);
            end else begin
                rvalid_i = 1'b0;
            end
            #1;
            if (c < 4) begin
                checks++; if (rready_o !== 1'b1) begin bad++; $display("FAIL b2b_accept c=%0d got=%b exp=1", c, rready_o); end
            end
            checks++; if (rvalid_o !== (c >= 2 && c < 6)) begin bad++; $display("FAIL b2b_rvalid c=%0d got=%b exp=%b", c, rvalid_o, (c >= 2 && c < 6)); end
            if (c >= 2 && c < 6) begin
                checks++; if (rtag_o !== 8'(8'h80 + c - 2)) begin bad++; $display("FAIL b2b_tag c=%0d got=%h exp=%h", c, rtag_o, 8'(8'h80 + c - 2)); end
                for (int l = 0; l < NL; l++) begin
                    checks++;
                    if (rdata_o[l*DW +: DW] !== memval(l, 32'(32'h200 + 32'h40*(c-2) + 8*l))) begin
                        bad++; $display("FAIL b2b_data c=%0d lane=%0d got=%h exp=%h", c, l, rdata_o[l*DW +: DW], memval(l, 32'(32'h200 + 32'h40*(c-2) + 8*l)));
                    end
                end
                $display("back_to_back: result tag %h", rtag_o);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int  got;
        bit  fired;
        rready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rvalid_i = 1'b1; ren_i = 3'b001; rtag_i = 8'(i); raddr_i = '0;
            raddr_i[AW-1:0] = 32'(32'h100 + 8*i);
            #1;
            checks++; if (rready_o !== 1'b1) begin bad++; $display("FAIL bp_accept i=%0d got=%b exp=1", i, rready_o); end
            step();
        end
        rtag_i = 8'd4; raddr_i[AW-1:0] = 32'h120;
        #1;
        checks++; if (rready_o !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", rready_o); end
        step();
        rready_i = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            #1;
            fired = rvalid_i && rready_o;
            if (fired) begin
                checks++; if (got < 1) begin bad++; $display("FAIL bp_5th_early got_results=%0d exp>=1", got); end
            end
            if (rvalid_o) begin
                checks++; if (rtag_o !== 8'(got)) begin bad++; $display("FAIL bp_order got=%h exp=%h", rtag_o, 8'(got)); end
                checks++; if (rdata_o !== {128'h0, memval(0, 32'(32'h100 + 8*got))}) begin
                    bad++; $display("FAIL bp_data got=%h exp=%h", rdata_o, memval(0, 32'(32'h100 + 8*got))); end
                $display("backpressure: result tag %h", rtag_o);
                got++;
            end
            step();
            if (fired) rvalid_i = 1'b0;
        end
        checks++; if (got != 5) begin bad++; $display("FAIL bp_timeout results=%0d exp=5", got); end
    endtask

    task automatic test_lane_stall();
        int wait_c;
        mem_q_ready_i = 3'b101;
        rvalid_i = 1'b1; ren_i = 3'b111; rtag_i = 8'h33;
        raddr_i = {32'h50, 32'h48, 32'h40};
        #1;
        checks++; if (rready_o !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b exp=1", rready_o); end
        step();
        rvalid_i = 1'b0;
        step();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (rvalid_o !== 1'b0 || mem_q_valid_o !== 3'b010) begin
                bad++; $display("FAIL stall_hold c=%0d rv=%b q=%b exp=0/010", c, rvalid_o, mem_q_valid_o);
            end
            step();
        end
        mem_q_ready_i = 3'b111;
        wait_c = 0;
        #1;
        while (!rvalid_o && wait_c < 5) begin step(); wait_c++; end
        checks++; if (rvalid_o !== 1'b1 || rtag_o !== 8'h33) begin bad++; $display("FAIL stall_release rv=%b tag=%h exp=1/33", rvalid_o, rtag_o); end
        checks++; if (rdata_o !== {64'hDA7A0002_00000050, 64'hDA7A0001_00000048, 64'hDA7A0000_00000040}) begin
            bad++; $display("FAIL stall_data got=%h", rdata_o); end
        $display("lane_stall: tag %h after %0d wait cycles", rtag_o, wait_c);
        step();
    endtask

    task automatic test_reset_mid();
        mem_q_ready_i = 3'b000; rready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rvalid_i = 1'b1; ren_i = 3'b111; rtag_i = 8'(8'hE1 + i);
            raddr_i = {32'h90, 32'h88, 32'h80};
            step();
        end
        rvalid_i = 1'b0;
        #1;
        checks++; if (mem_q_valid_o !== 3'b111) begin bad++; $display("FAIL rmid_pending got=%b exp=111", mem_q_valid_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (rvalid_o !== 1'b0 || rready_o !== 1'b0 || mem_q_valid_o !== 3'b000) begin
            bad++; $display("FAIL rmid_outputs rv=%b rr=%b q=%b exp=0/0/000", rvalid_o, rready_o, mem_q_valid_o); end
        step();
        rst_ni = 1'b1;
        step(); step();
        mem_q_ready_i = 3'b111;
        #1;
        checks++; if (mem_q_valid_o !== 3'b000 || rvalid_o !== 1'b0) begin bad++; $display("FAIL rmid_cleared q=%b rv=%b exp=000/0", mem_q_valid_o, rvalid_o); end
        rvalid_i = 1'b1; ren_i = 3'b111; rtag_i = 8'h77; raddr_i = {32'h70, 32'h68, 32'h60};
        #1;
        checks++; if (rready_o !== 1'b1) begin bad++; $display("FAIL rmid_accept got=%b exp=1", rready_o); end
        step();
        rvalid_i = 1'b0;
        #1;
        checks++; if (rvalid_o !== 1'b0 || mem_q_valid_o !== 3'b111) begin bad++; $display("FAIL rmid_t1 rv=%b q=%b exp=0/111", rvalid_o, mem_q_valid_o); end
        step();
        checks++; if (rvalid_o !== 1'b1 || rtag_o !== 8'h77) begin bad++; $display("FAIL rmid_t2 rv=%b tag=%h exp=1/77", rvalid_o, rtag_o); end
        checks++; if (rdata_o !== {64'hDA7A0002_00000070, 64'hDA7A0001_00000068, 64'hDA7A0000_00000060}) begin
            bad++; $display("FAIL rmid_data got=%h", rdata_o); end
        $display("reset_mid: tag %h after reset", rtag_o);
        step();
    endtask

    task automatic test_perf();
        logic [31:0] exp_issue, exp_stall;
`ifdef SNITCH_VFPR_PERF_EN
        exp_issue = 32'd4; exp_stall = 32'd3;
`else
        exp_issue = 32'd0; exp_stall = 32'd0;
`endif
        rst_ni = 1'b0; rvalid_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step(); step();
        rready_i = 1'b0; mem_q_ready_i = 3'b111;
        for (int i = 0; i < 7; i++) begin
            rvalid_i = 1'b1; ren_i = 3'b000; rtag_i = 8'(8'hC0 + i);
            #1;
            checks++; if (rready_o !== (i < 4)) begin bad++; $display("FAIL perf_ready i=%0d got=%b exp=%b", i, rready_o, (i < 4)); end
            step();
        end
        rvalid_i = 1'b0;
        #1;
        checks++; if (perf_stall_o !== exp_stall) begin bad++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall_o, exp_stall); end
        checks++; if (perf_issue_o !== exp_issue) begin bad++; $display("FAIL perf_issue got=%0d exp=%0d", perf_issue_o, exp_issue); end
        rready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rvalid_o !== 1'b1 || rtag_o !== 8'(8'hC0 + i)) begin
                bad++; $display("FAIL perf_drain i=%0d rv=%b tag=%h exp=1/%h", i, rvalid_o, rtag_o, 8'(8'hC0 + i)); end
            step();
        end
        $display("perf: issue=%0d stall=%0d", perf_issue_o, perf_stall_o);
    endtask

    initial begin
        test_reset();
        test_full_lanes();
        test_zero_mask();
        test_back_to_back();
        test_backpressure();
        test_lane_stall();
        test_reset_mid();
        test_perf();
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
